// File: rtl/vend_ctrl.sv
// Vending-machine controller: four slots at a common price, with coin
// acceptance, product selection, dispenser handshake with a timeout,
// change return and per-slot stock tracking. All outputs are registered.
module vend_ctrl #(
    parameter int PRICE      = 15,
    parameter int STOCK_INIT = 3,
    parameter int TIMEOUT    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [4:0] coin,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       restock,
    input  logic       disp_done,
    output logic       disp_req,
    output logic [1:0] disp_slot,
    output logic [7:0] credit,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       coin_rej,
    output logic       sel_err,
    output logic       fault,
    output logic [3:0] empty
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [7:0]       PRICE_C  = 8'(PRICE);
    localparam logic [3:0]       STOCK_C  = 4'(STOCK_INIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [3:0]       stock [4];
    logic [CNT_W-1:0] cnt;

    // Credit plus incoming coin, one bit wider so an overflow past 255 is visible.
    logic [8:0] sum;
    // Credit left over after paying for the item being dispensed.
    logic [7:0] remain;

    assign sum    = {1'b0, credit} + {4'b0000, coin};
    assign remain = credit - PRICE_C;

    // Only 5, 10 and 25 cent coins are accepted.
    function automatic logic coin_ok(input logic [4:0] c);
        return (c == 5'd5) || (c == 5'd10) || (c == 5'd25);
    endfunction

    // Main controller FSM: state, credit, stock, dispense timer and all pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= 8'd0;
            cnt          <= '0;
            disp_req     <= 1'b0;
            disp_slot    <= 2'd0;
            change_valid <= 1'b0;
            change_amt   <= 8'd0;
            coin_rej     <= 1'b0;
            sel_err      <= 1'b0;
            fault        <= 1'b0;
            for (int i = 0; i < 4; i++) stock[i] <= STOCK_C;
        end else begin
            // Pulse outputs default low; a branch below raises them for one cycle.
            coin_rej     <= 1'b0;
            sel_err      <= 1'b0;
            fault        <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= 8'd0;
            case (state)
                IDLE, CREDIT: begin
                    if (state == IDLE && restock) begin
                        for (int i = 0; i < 4; i++) stock[i] <= STOCK_C;
                    end
                    // cancel beats coin beats selection; losers are dropped silently.
                    if (state == CREDIT && cancel) begin
                        state        <= CHANGE;
                        change_valid <= 1'b1;
                        change_amt   <= credit;
                        credit       <= 8'd0;
                    end else if (coin_valid) begin
                        if (coin_ok(coin) && !sum[8]) begin
                            credit <= sum[7:0];
                            state  <= CREDIT;
                        end else begin
                            coin_rej <= 1'b1;
                        end
                    end else if (sel_valid) begin
                        if (state == CREDIT && credit >= PRICE_C && stock[sel] != 4'd0) begin
                            state     <= VEND;
                            disp_req  <= 1'b1;
                            disp_slot <= sel;
                            cnt       <= '0;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    if (coin_valid) coin_rej <= 1'b1;
                    if (disp_done) begin
                        stock[disp_slot] <= stock[disp_slot] - 4'd1;
                        disp_req         <= 1'b0;
                        credit           <= 8'd0;
                        if (remain != 8'd0) begin
                            state        <= CHANGE;
                            change_valid <= 1'b1;
                            change_amt   <= remain;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Dispenser never answered: refund everything, keep stock.
                        fault        <= 1'b1;
                        disp_req     <= 1'b0;
                        state        <= CHANGE;
                        change_valid <= 1'b1;
                        change_amt   <= credit;
                        credit       <= 8'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHANGE: begin
                    if (coin_valid) coin_rej <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered empty flags, one cycle behind the stock registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            empty <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) empty[i] <= (stock[i] == 4'd0);
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed testbench for vend_ctrl with default parameters
// (PRICE 15, STOCK_INIT 3, TIMEOUT 200).
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [4:0] coin;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       restock;
    logic       disp_done;
    logic       disp_req;
    logic [1:0] disp_slot;
    logic [7:0] credit;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_rej;
    logic       sel_err;
    logic       fault;
    logic [3:0] empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin        (coin),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .restock     (restock),
        .disp_done   (disp_done),
        .disp_req    (disp_req),
        .disp_slot   (disp_slot),
        .credit      (credit),
        .change_valid(change_valid),
        .change_amt  (change_amt),
        .coin_rej    (coin_rej),
        .sel_err     (sel_err),
        .fault       (fault),
        .empty       (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        cancel     = 1'b0;
        restock    = 1'b0;
        disp_done  = 1'b0;
    endtask

    task automatic put_coin(input int v);
        coin_valid = 1'b1;
        coin       = 5'(v);
        step();
        clr();
    endtask

    // Exact-price purchase from one slot, dispenser answering immediately.
    task automatic buy(input int slot);
        put_coin(5);
        put_coin(5);
        put_coin(5);
        chk("buy_credit", credit, 15);
        sel_valid = 1'b1;
        sel       = 2'(slot);
        step();
        clr();
        chk("buy_req", disp_req, 1);
        chk("buy_slot", disp_slot, slot);
        disp_done = 1'b1;
        step();
        clr();
        chk("buy_req_drop", disp_req, 0);
        chk("buy_no_change", change_valid, 0);
        chk("buy_credit0", credit, 0);
    endtask

    initial begin
        int hi;
        int flt;
        clr();
        coin = 5'd0;
        sel  = 2'd0;
        rst  = 1'b1;
        step();
        step();
        chk("rst_credit", credit, 0);
        chk("rst_req", disp_req, 0);
        chk("rst_slot", disp_slot, 0);
        chk("rst_empty", empty, 0);
        chk("rst_chg", change_valid, 0);
        chk("rst_amt", change_amt, 0);
        chk("rst_pulses", {coin_rej, sel_err, fault}, 0);
        rst = 1'b0;
        step();

        // Selection in IDLE is refused; disp_done in IDLE is ignored.
        sel_valid = 1'b1; sel = 2'd0;
        step(); clr();
        chk("idle_sel_err", sel_err, 1);
        disp_done = 1'b1;
        step(); clr();
        chk("idle_done_req", disp_req, 0);
        chk("idle_done_chg", change_valid, 0);
        chk("idle_sel_err_pulse", sel_err, 0);

        // 10+10, slot 2, disp_done on the third cycle -> change 5.
        put_coin(10);
        chk("c10_credit", credit, 10);
        put_coin(10);
        chk("c20_credit", credit, 20);
        sel_valid = 1'b1; sel = 2'd2;
        step(); clr();
        chk("v1_req_c1", disp_req, 1);
        chk("v1_slot", disp_slot, 2);
        chk("v1_credit", credit, 20);
        step();
        chk("v1_req_c2", disp_req, 1);
        coin_valid = 1'b1; coin = 5'd10;
        step(); clr();
        chk("v1_req_c3", disp_req, 1);
        chk("v1_vend_coin_rej", coin_rej, 1);
        disp_done = 1'b1;
        step(); clr();
        chk("v1_req_drop", disp_req, 0);
        chk("v1_chg_valid", change_valid, 1);
        chk("v1_chg_amt", change_amt, 5);
        chk("v1_credit0", credit, 0);
        step();
        chk("v1_chg_pulse", change_valid, 0);
        chk("v1_amt_zero", change_amt, 0);

        // Coin 7 rejected; coin 5 beats a same-cycle selection.
        put_coin(7);
        chk("c7_rej", coin_rej, 1);
        chk("c7_credit", credit, 0);
        coin_valid = 1'b1; coin = 5'd5; sel_valid = 1'b1; sel = 2'd0;
        step(); clr();
        chk("c5_credit", credit, 5);
        chk("c5_no_rej", coin_rej, 0);
        chk("c5_no_selerr", sel_err, 0);
        chk("c5_no_req", disp_req, 0);
        cancel = 1'b1;
        step(); clr();
        chk("cancel5_valid", change_valid, 1);
        chk("cancel5_amt", change_amt, 5);
        step();

        // Coin 25, slot 1, no disp_done -> timeout after 200 cycles.
        put_coin(25);
        sel_valid = 1'b1; sel = 2'd1;
        step(); clr();
        chk("to_req_start", disp_req, 1);
        hi  = 1;
        flt = 0;
        for (int k = 1; k < 200; k++) begin
            step();
            if (disp_req) hi++;
            if (fault || change_valid) flt++;
        end
        chk("to_req_cycles", hi, 200);
        chk("to_no_early_fault", flt, 0);
        step();
        chk("to_fault", fault, 1);
        chk("to_req_drop", disp_req, 0);
        chk("to_chg_valid", change_valid, 1);
        chk("to_chg_amt", change_amt, 25);
        chk("to_credit0", credit, 0);
        step();
        chk("to_fault_pulse", fault, 0);

        // Empty slot 0 with three sales, then a refused selection and a refund.
        buy(0);
        buy(0);
        buy(0);
        step();
        chk("empty0", empty, 4'b0001);
        put_coin(25);
        sel_valid = 1'b1; sel = 2'd0;
        step(); clr();
        chk("empty_sel_err", sel_err, 1);
        chk("empty_sel_credit", credit, 25);
        chk("empty_sel_req", disp_req, 0);
        cancel = 1'b1;
        step(); clr();
        chk("empty_refund_amt", change_amt, 25);
        step();

        // Slot 2 had two left, slot 1 still holds all three after the timeout.
        buy(2);
        buy(2);
        buy(1);
        buy(1);
        buy(1);
        step();
        chk("empty_012", empty, 4'b0111);

        // Credit ceiling: 250, +25 rejected, +5 reaches 255, +5 rejected.
        for (int k = 0; k < 10; k++) put_coin(25);
        chk("c250_credit", credit, 250);
        put_coin(25);
        chk("c275_rej", coin_rej, 1);
        chk("c275_credit", credit, 250);
        put_coin(5);
        chk("c255_credit", credit, 255);
        chk("c255_no_rej", coin_rej, 0);
        put_coin(5);
        chk("c260_rej", coin_rej, 1);
        chk("c260_credit", credit, 255);

        // Restock while holding credit is ignored.
        restock = 1'b1;
        step(); clr();
        step();
        chk("restock_credit_ign", empty, 4'b0111);
        cancel = 1'b1;
        step(); clr();
        chk("c255_refund", change_amt, 255);
        step();

        // Restock in IDLE refills every slot.
        restock = 1'b1;
        step(); clr();
        step();
        chk("restock_idle", empty, 4'b0000);

        // Reset in the middle of a dispense.
        put_coin(25);
        sel_valid = 1'b1; sel = 2'd3;
        step(); clr();
        chk("rv_req", disp_req, 1);
        step();
        rst = 1'b1; disp_done = 1'b1;
        step(); clr();
        rst = 1'b0;
        chk("rv_req_drop", disp_req, 0);
        chk("rv_credit", credit, 0);
        chk("rv_no_chg", change_valid, 0);
        chk("rv_no_fault", fault, 0);
        step();
        step();
        chk("rv_empty", empty, 0);
        chk("rv_no_chg_late", change_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 15, price of every slot in cents (1..255).
REQ-002 SHALL have parameter STOCK_INIT, default 3, per-slot item count loaded at reset and restock (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 200, number of cycles in VEND to wait for disp_done before faulting (>=2).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port coin_valid  input  1  one-cycle strobe qualifying coin.
REQ-007 SHALL have port coin  input  5  coin value in cents.
REQ-008 SHALL have port sel_valid  input  1  one-cycle product-selection strobe.
REQ-009 SHALL have port sel  input  2  selected slot 0..3.
REQ-010 SHALL have port cancel  input  1  one-cycle refund request.
REQ-011 SHALL have port restock  input  1  one-cycle strobe reloading all slots to STOCK_INIT.
REQ-012 SHALL have port disp_done  input  1  dispenser-mechanism completion strobe.
REQ-013 SHALL have port disp_req  output  1  level; held high while dispenser is commanded.
REQ-014 SHALL have port disp_slot  output  2  slot being dispensed; valid while disp_req high.
REQ-015 SHALL have port credit  output  8  current accumulated credit in cents.
REQ-016 SHALL have port change_valid  output  1  one-cycle strobe qualifying change_amt.
REQ-017 SHALL have port change_amt  output  8  cents to return; 0 when change_valid low.
REQ-018 SHALL have port coin_rej  output  1  one-cycle pulse, coin returned unaccepted.
REQ-019 SHALL have port sel_err  output  1  one-cycle pulse, selection refused.
REQ-020 SHALL have port fault  output  1  one-cycle pulse, dispense timeout.
REQ-021 SHALL have port empty  output  4  bit i high when slot i stock is 0.

Function
REQ-022 SHALL implement states IDLE (credit 0), CREDIT, VEND, CHANGE; all outputs registered.
REQ-023 Valid coins SHALL be 5, 10, 25; any other value with coin_valid SHALL pulse coin_rej the next cycle, credit unchanged.
REQ-024 In IDLE/CREDIT a valid coin SHALL add to credit next cycle and move IDLE->CREDIT; if credit+coin > 255 the coin SHALL be rejected (coin_rej).
REQ-025 Any coin_valid in VEND or CHANGE SHALL be rejected with coin_rej.
REQ-026 Priority in CREDIT, same cycle: cancel > coin_valid > sel_valid; a lower-priority strobe is dropped silently (no sel_err).
REQ-027 sel_valid in CREDIT with credit >= PRICE and stock[sel] > 0 SHALL enter VEND next cycle with disp_req=1, disp_slot=sel.
REQ-028 sel_valid otherwise (IDLE, credit < PRICE, or slot empty) SHALL pulse sel_err next cycle, state and credit unchanged.
REQ-029 disp_req SHALL remain high in VEND until disp_done sampled high or timeout; disp_done outside VEND SHALL be ignored.
REQ-030 On disp_done: stock[disp_slot] decrements, credit becomes credit-PRICE, disp_req drops next cycle; go to CHANGE if remainder > 0 else IDLE.
REQ-031 VEND cycle counter SHALL start at 0 on entry; if TIMEOUT cycles elapse without disp_done: fault pulse, disp_req drops, stock unchanged, full credit refunded via CHANGE.
REQ-032 cancel in CREDIT SHALL go to CHANGE refunding full credit; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-033 CHANGE SHALL last exactly one cycle: change_valid=1, change_amt=refund, credit=0, next state IDLE.
REQ-034 restock SHALL reload all four stocks to STOCK_INIT only in IDLE; ignored in other states.
REQ-035 empty SHALL reflect stock registers combinationally-free (registered, updated the cycle after stock changes).

Reset
REQ-036 rst SHALL force state IDLE, credit 0, all stocks STOCK_INIT, counter 0, empty 0, disp_req/change_valid/coin_rej/sel_err/fault 0, change_amt 0, disp_slot 0.
REQ-037 rst during VEND SHALL drop disp_req next cycle with no refund, no fault and no stock decrement.
REQ-038 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-039 Coins 10,10 then sel=2, disp_done 3 cycles later -> disp_req high 3 cycles, disp_slot 2, change_valid with change_amt 5, credit 0, stock[2]=2.
REQ-040 Coin 7, then coin 5 with sel same cycle -> coin_rej pulse; credit 5; no sel_err; no disp_req.
REQ-041 Coin 25 then sel=1 without disp_done -> fault after TIMEOUT=200 cycles, change_amt 25, stock[1]=3.
REQ-042 Coins 5,5,5 and sel=0 three times with disp_done -> empty[0]=1; fourth coin 25 + sel=0 -> sel_err, credit 25; cancel -> change_amt 25.
REQ-043 Ten 25-cent coins then 25 -> last coin rejected (250+25>255), credit 250.
REQ-044 rst asserted mid-VEND -> next cycle disp_req 0, credit 0, no change_valid, stocks 3; restock in CREDIT ignored.
